// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte-stream requesters.
// A requester keeps the grant across a multi-byte packet until it sends a byte with
// req_last set. Each frame is timed locally from the same baud and clock parameters
// that the transmitter uses.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ             = 4,
    parameter int unsigned BYTESIZES           = 8,
    parameter int unsigned BAUDRATE            = 115200,
    parameter int unsigned COUNTER_CLOCK_INPUT = 50_000_000,
    parameter int unsigned STOP_BITS           = 1,
    parameter int unsigned GAP_BITS            = 0
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*BYTESIZES-1:0]   req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           tx_valid,
    output logic [BYTESIZES-1:0]           tx_data,
    output logic                           busy,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id
);

    localparam int unsigned IdW        = $clog2(NUM_REQ);
    localparam int unsigned ClksPerBit = COUNTER_CLOCK_INPUT / BAUDRATE;
    localparam int unsigned FrameClks  = ClksPerBit * (1 + BYTESIZES + STOP_BITS);
    localparam int unsigned GapClks    = ClksPerBit * GAP_BITS;

    // Reject configurations the arbiter is not built for.
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : gen_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ must be 2..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : gen_bad_stop_bits
        $error("uart_tx_arbiter: STOP_BITS must be 1 or 2");
    end
    if (ClksPerBit == 0) begin : gen_bad_baud
        $error("uart_tx_arbiter: clock too slow for BAUDRATE");
    end

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StGap
    } state_e;

    state_e               state_q, state_d;
    logic [31:0]          cnt_q, cnt_d;
    logic [IdW-1:0]       rr_q, rr_d;
    logic                 lock_q, lock_d;
    logic [IdW-1:0]       grant_q, grant_d;
    logic [BYTESIZES-1:0] data_q, data_d;

    logic [BYTESIZES-1:0] req_bytes [NUM_REQ];
    logic                 pick_found;
    logic [IdW-1:0]       pick_idx;
    logic [IdW-1:0]       cand_id;
    logic [31:0]          cand;

    // Split the flat data bus into one byte per requester.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_bytes[i] = req_data[i*BYTESIZES +: BYTESIZES];
        end
    end

    // Choose the requester to serve: the locked one only, else round-robin from rr+1.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        cand_id    = '0;
        if (lock_q) begin
            if (req_valid[grant_q]) begin
                pick_found = 1'b1;
                pick_idx   = grant_q;
            end
        end else begin
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                cand = 32'(rr_q) + k;
                if (cand >= NUM_REQ) begin
                    cand = cand - NUM_REQ;
                end
                cand_id = IdW'(cand);
                if (!pick_found && req_valid[cand_id]) begin
                    pick_found = 1'b1;
                    pick_idx   = cand_id;
                end
            end
        end
    end

    // Next-state logic: grant in idle, time the frame in send, time the idle gap.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_d      = rr_q;
        lock_d    = lock_q;
        grant_d   = grant_q;
        data_d    = data_q;
        req_ready = '0;

        unique case (state_q)
            StIdle: begin
                // The handshake is suppressed while reset is asserted so no byte is lost.
                if (pick_found && !reset) begin
                    req_ready[pick_idx] = 1'b1;
                    data_d              = req_bytes[pick_idx];
                    grant_d             = pick_idx;
                    rr_d                = pick_idx;
                    lock_d              = ~req_last[pick_idx];
                    cnt_d               = '0;
                    state_d             = StSend;
                end
            end
            StSend: begin
                if (cnt_q == FrameClks - 1) begin
                    cnt_d   = '0;
                    state_d = (GapClks > 0) ? StGap : StIdle;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StGap: begin
                if (cnt_q == GapClks - 1) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rr_q    <= '0;
            lock_q  <= 1'b0;
            grant_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            lock_q  <= lock_d;
            grant_q <= grant_d;
            data_q  <= data_d;
        end
    end

    // Outputs come straight from registered state.
    always_comb begin
        tx_valid = (state_q == StSend);
        tx_data  = data_q;
        busy     = (state_q != StIdle) | lock_q;
        grant_id = grant_q;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a timestamp-based reference model checked
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int BS    = 8;
    localparam int BAUD  = 93_000;
    localparam int FCLK  = 1_000_000;
    localparam int SB    = 2;
    localparam int GB    = 1;
    // 1e6/93000 truncates to 10 clocks per bit
    localparam int CPB   = FCLK / BAUD;
    localparam int FRAME = CPB * (1 + BS + SB);
    localparam int GAP   = CPB * GB;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*BS-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            tx_valid;
    logic [BS-1:0]   tx_data;
    logic            busy;
    logic [1:0]      grant_id;

    uart_tx_arbiter #(
        .NUM_REQ             (N),
        .BYTESIZES           (BS),
        .BAUDRATE            (BAUD),
        .COUNTER_CLOCK_INPUT (FCLK),
        .STOP_BITS           (SB),
        .GAP_BITS            (GB)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: arbiter is free from free_at, line busy in [s_start, s_end].
    longint    cyc = 0;
    longint    free_at = 0;
    longint    s_start = 1;
    longint    s_end = 0;
    bit        m_lock = 0;
    int        m_rr = 0;
    int        m_grant = 0;
    logic [BS-1:0] m_data = '0;
    bit        model_ok = 0;

    // Observation logs used by the literal checks.
    int grant_log[$];
    int data_log[$];
    int hi_runs[$];
    int lo_runs[$];
    int hi_run = 0;
    int lo_run = 0;
    bit prev_tv = 0;
    bit seen_fall = 0;
    int ready_cnt[N];

    // Stimulus state: pending {last, byte} per requester.
    logic [8:0] pend[N][$];
    bit [N-1:0] seen_ready = '0;
    bit [N-1:0] hold_off = '0;
    bit         rnd_mode = 0;
    bit         rst_req = 1;

    task automatic check(input string name, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic check_q(input string name, input int got[$], input int exp[$]);
        check({name, "_count"}, got.size(), exp.size());
        for (int k = 0; k < exp.size() && k < got.size(); k++) begin
            check($sformatf("%s[%0d]", name, k), got[k], exp[k]);
        end
    endtask

    task automatic model_reset();
        free_at = cyc + 1;
        s_start = 1;
        s_end   = 0;
        m_lock  = 0;
        m_rr    = 0;
        m_grant = 0;
        m_data  = '0;
    endtask

    // Per-cycle compare against the model, then advance the model past this edge.
    task automatic check_cycle();
        int           pick;
        logic [N-1:0] er;
        bit           idle;
        bit           etv;
        bit           ebusy;
        if (!model_ok) begin
            if (reset) begin
                model_reset();
                model_ok = 1;
            end
        end else begin
            pick = -1;
            idle = (cyc >= free_at);
            if (!reset && idle) begin
                if (m_lock) begin
                    if (req_valid[m_grant]) pick = m_grant;
                end else begin
                    for (int k = 1; k <= N; k++) begin
                        int j;
                        j = (m_rr + k) % N;
                        if (pick < 0 && req_valid[j]) pick = j;
                    end
                end
            end
            er    = (pick >= 0) ? N'(1 << pick) : '0;
            etv   = (cyc >= s_start) && (cyc <= s_end);
            ebusy = !idle || m_lock;
            n_tests++;
            if ({req_ready, tx_valid, tx_data, busy, grant_id} !==
                {er, etv, m_data, ebusy, 2'(m_grant)}) begin
                n_fail++;
                $display({"FAIL cycle %0d: ready=%b tx_valid=%b tx_data=%h busy=%b grant_id=%0d,",
                          " required ready=%b tx_valid=%b tx_data=%h busy=%b grant_id=%0d"},
                         cyc, req_ready, tx_valid, tx_data, busy, grant_id,
                         er, etv, m_data, ebusy, m_grant);
            end
            if (reset) begin
                model_reset();
            end else if (pick >= 0) begin
                s_start = cyc + 1;
                s_end   = cyc + FRAME;
                free_at = cyc + 1 + FRAME + GAP;
                m_data  = req_data[pick*BS +: BS];
                m_grant = pick;
                m_rr    = pick;
                m_lock  = !req_last[pick];
            end
        end
        // Logging of observed behaviour.
        if (reset) begin
            prev_tv   = 0;
            hi_run    = 0;
            lo_run    = 0;
            seen_fall = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req_ready[i] === 1'b1) begin
                    grant_log.push_back(i);
                    ready_cnt[i]++;
                end
            end
            if (tx_valid === 1'b1) begin
                if (!prev_tv) begin
                    data_log.push_back(int'(tx_data));
                    if (seen_fall) lo_runs.push_back(lo_run);
                end
                hi_run++;
                prev_tv = 1;
            end else begin
                if (prev_tv) begin
                    hi_runs.push_back(hi_run);
                    hi_run    = 0;
                    lo_run    = 0;
                    seen_fall = 1;
                end
                lo_run++;
                prev_tv = 0;
            end
        end
        seen_ready = req_ready;
        cyc++;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (seen_ready[i] && pend[i].size() > 0) void'(pend[i].pop_front());
            if (rnd_mode) begin
                if (pend[i].size() == 0 && $urandom_range(0, 15) == 0) begin
                    pend[i].push_back({($urandom_range(0, 2) == 0), 8'($urandom)});
                end
                hold_off[i] = ($urandom_range(0, 31) == 0);
            end else begin
                hold_off[i] = 0;
            end
            if (pend[i].size() > 0 && !hold_off[i]) begin
                req_valid[i]          = 1'b1;
                req_data[i*BS +: BS]  = pend[i][0][7:0];
                req_last[i]           = pend[i][0][8];
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*BS +: BS]  = 8'($urandom);
                req_last[i]           = 1'($urandom);
            end
        end
        reset = rnd_mode ? ($urandom_range(0, 4999) == 0) : rst_req;
    endtask

    task automatic step();
        @(negedge clock);
        check_cycle();
        @(posedge clock);
        #1;
        drive();
    endtask

    task automatic clear_logs();
        grant_log.delete();
        data_log.delete();
        hi_runs.delete();
        lo_runs.delete();
        seen_fall = 0;
        for (int i = 0; i < N; i++) ready_cnt[i] = 0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        bit done;
        int n;
        done = 0;
        n    = 0;
        while (!done && n < budget) begin
            step();
            n++;
            done = (busy === 1'b0) && (req_valid == '0);
            for (int i = 0; i < N; i++) if (pend[i].size() > 0) done = 0;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: not idle after %0d cycles, required idle", name, budget);
        end
    endtask

    task automatic wait_grant(input string name, input int budget);
        int n;
        n = 0;
        while (grant_log.size() == 0 && n < budget) begin
            step();
            n++;
        end
        if (grant_log.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: no grant in %0d cycles, required a grant", name, budget);
        end
    endtask

    // Directed scenarios followed by randomized traffic.
    initial begin
        int exp_q[$];
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;

        // Reset values
        repeat (3) step();
        rst_req = 0;
        step();
        check("rst_tx_valid", tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_req_ready", req_ready, 0);

        // Single byte from requester 0
        clear_logs();
        pend[0].push_back({1'b1, 8'h80});
        wait_drain("t1", 400);
        exp_q = '{0};
        check_q("t1_grants", grant_log, exp_q);
        exp_q = '{8'h80};
        check_q("t1_data", data_log, exp_q);
        exp_q = '{110};
        check_q("t1_frame_len", hi_runs, exp_q);

        // All four requesters, two single-byte packets each
        clear_logs();
        for (int i = 0; i < N; i++) begin
            pend[i].push_back({1'b1, 8'(8'h11 * (i + 1))});
            pend[i].push_back({1'b1, 8'(8'h55 + i)});
        end
        wait_drain("t2", 3000);
        exp_q = '{1, 2, 3, 0, 1, 2, 3, 0};
        check_q("t2_grants", grant_log, exp_q);
        exp_q = '{8'h22, 8'h33, 8'h44, 8'h11, 8'h56, 8'h57, 8'h58, 8'h55};
        check_q("t2_data", data_log, exp_q);
        exp_q = '{110, 110, 110, 110, 110, 110, 110, 110};
        check_q("t2_frame_len", hi_runs, exp_q);
        exp_q = '{11, 11, 11, 11, 11, 11, 11};
        check_q("t2_gap_len", lo_runs, exp_q);
        for (int i = 0; i < N; i++) check($sformatf("t2_ready_cnt%0d", i), ready_cnt[i], 2);

        // Locked three-byte packet from requester 2 while requester 0 waits
        clear_logs();
        pend[2].push_back({1'b0, 8'hA1});
        pend[2].push_back({1'b0, 8'hA2});
        pend[2].push_back({1'b1, 8'hA3});
        pend[0].push_back({1'b1, 8'hB0});
        wait_drain("t3", 2000);
        exp_q = '{2, 2, 2, 0};
        check_q("t3_grants", grant_log, exp_q);
        exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'hB0};
        check_q("t3_data", data_log, exp_q);

        // Reset in the middle of a frame
        clear_logs();
        pend[1].push_back({1'b1, 8'hC5});
        wait_grant("t4", 20);
        repeat (50) step();
        rst_req = 1;
        step();
        rst_req = 0;
        step();
        check("t4_tx_valid", tx_valid, 0);
        check("t4_busy", busy, 0);
        check("t4_grant_id", grant_id, 0);
        clear_logs();
        pend[3].push_back({1'b1, 8'h3C});
        wait_drain("t4", 400);
        exp_q = '{3};
        check_q("t4_grants", grant_log, exp_q);
        exp_q = '{8'h3C};
        check_q("t4_data", data_log, exp_q);
        check("t4_grant_id_after", grant_id, 3);

        // Locked requester stalls mid-packet, then finishes
        clear_logs();
        pend[1].push_back({1'b0, 8'hC1});
        wait_grant("t5", 20);
        pend[0].push_back({1'b1, 8'hD0});
        pend[2].push_back({1'b1, 8'hD2});
        pend[3].push_back({1'b1, 8'hD3});
        clear_logs();
        repeat (1000) step();
        check("t5_no_grants", grant_log.size(), 0);
        check("t5_busy_held", busy, 1);
        pend[1].push_back({1'b1, 8'hC2});
        wait_drain("t5", 2000);
        exp_q = '{1, 2, 3, 0};
        check_q("t5_grants", grant_log, exp_q);

        // Randomized traffic with valid drops and occasional resets
        rnd_mode = 1;
        repeat (40000) step();
        rnd_mode = 0;
        repeat (5) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
